// File: rtl/spi_reg_ctrl_pkg.sv
// Shared types and helpers for the SPI register controller.
package spi_reg_ctrl_pkg;

  typedef enum logic [1:0] {IDLE, CMD, DATA, DRAIN} state_e;

  // R/W flag sits this many bits below the command byte width (WIDTH-1).
  localparam int CMD_RW_MSB_OFS = 1;

  function automatic int addr_w(input int nreg);
    return (nreg > 1) ? $clog2(nreg) : 1;
  endfunction

endpackage

// File: rtl/spi_reg_ctrl_reg_file.sv
// NREG x WIDTH register array: one synchronous write port, one async read port.
module spi_reg_file
  import spi_reg_ctrl_pkg::*;
#(
  parameter int WIDTH = 8,
  parameter int NREG  = 16,
  parameter int AW    = addr_w(NREG)
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  we_i,
  input  logic [AW-1:0]         waddr_i,
  input  logic [WIDTH-1:0]      wdata_i,
  input  logic [AW-1:0]         raddr_i,
  output logic [WIDTH-1:0]      rdata_o,
  output logic [NREG*WIDTH-1:0] q_o
);

  logic [NREG-1:0][WIDTH-1:0] mem_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst)       mem_q <= '0;
    else if (we_i) mem_q[waddr_i] <= wdata_i;
  end

  // Read returns the pre-write value when read and write hit the same entry.
  assign rdata_o = mem_q[raddr_i];
  assign q_o     = mem_q;

endmodule

// File: rtl/spi_reg_ctrl.sv
// SPI byte-stream to register-file bridge: command byte (R/W + address), then data.
// Define SPI_REG_CTRL_AUTOINC_EN for burst access with wrapping address increment.
module spi_reg_ctrl
  import spi_reg_ctrl_pkg::*;
#(
  parameter int WIDTH = 8,
  parameter int NREG  = 16
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      spi_ss_n,
  input  logic                      spi_ready,
  output logic                      spi_en,
  input  logic [WIDTH-1:0]          spi_rx_data,
  output logic [WIDTH-1:0]          spi_tx_data,
  output logic [NREG*WIDTH-1:0]     reg_q,
  output logic                      wr_stb,
  output logic [addr_w(NREG)-1:0]   wr_addr,
  output logic                      err,
  input  logic                      err_clr
);

  localparam int AW = addr_w(NREG);
  localparam int RW = WIDTH - CMD_RW_MSB_OFS;

  state_e           state_q, state_d;
  logic             rdy_q, en_q, en_d;
  logic [WIDTH-1:0] tx_q, tx_d;
  logic [AW-1:0]    addr_q, addr_d, wr_addr_q, wr_addr_d, raddr;
  logic             rd_q, rd_d, bad_q, bad_d, wr_stb_q, wr_stb_d;
  logic             err_q, err_d, need_hi_q, need_hi_d;
  logic [WIDTH-1:0] rdata;
  logic [WIDTH-2:0] cmd_fld;
  logic             cmd_bad, hs, we;

  assign cmd_fld = spi_rx_data[WIDTH-2:0];
  // Compare the full address field so out-of-range upper bits are not aliased.
  assign cmd_bad = 32'(cmd_fld) >= 32'(NREG);
  assign hs      = en_q && !spi_ss_n;
  assign we      = hs && (state_q == DATA) && !rd_q && !bad_q;

  spi_reg_file #(.WIDTH(WIDTH), .NREG(NREG), .AW(AW)) u_rf (
    .clk    (clk),
    .rst    (rst),
    .we_i   (we),
    .waddr_i(addr_q),
    .wdata_i(spi_rx_data),
    .raddr_i(raddr),
    .rdata_o(rdata),
    .q_o    (reg_q)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= IDLE;
      rdy_q     <= 1'b0;
      en_q      <= 1'b0;
      tx_q      <= '0;
      addr_q    <= '0;
      rd_q      <= 1'b0;
      bad_q     <= 1'b0;
      wr_stb_q  <= 1'b0;
      wr_addr_q <= '0;
      err_q     <= 1'b0;
      need_hi_q <= 1'b1;
    end else begin
      state_q   <= state_d;
      rdy_q     <= spi_ready;
      en_q      <= en_d;
      tx_q      <= tx_d;
      addr_q    <= addr_d;
      rd_q      <= rd_d;
      bad_q     <= bad_d;
      wr_stb_q  <= wr_stb_d;
      wr_addr_q <= wr_addr_d;
      err_q     <= err_d;
      need_hi_q <= need_hi_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    en_d      = spi_ready && !rdy_q;
    tx_d      = tx_q;
    addr_d    = addr_q;
    rd_d      = rd_q;
    bad_d     = bad_q;
    wr_stb_d  = 1'b0;
    wr_addr_d = wr_addr_q;
    err_d     = err_q && !err_clr;
    need_hi_d = need_hi_q;
    raddr     = addr_q;
    case (state_q)
      IDLE: begin
        tx_d = '0;
        if (!spi_ss_n && !need_hi_q) state_d = CMD;
      end
      CMD: if (hs) begin
        addr_d  = AW'(cmd_fld);
        raddr   = AW'(cmd_fld);
        rd_d    = spi_rx_data[RW];
        bad_d   = cmd_bad;
        tx_d    = (spi_rx_data[RW] && !cmd_bad) ? rdata : '0;
        if (cmd_bad) err_d = 1'b1;
        state_d = DATA;
      end
      DATA: if (hs) begin
        if (!rd_q && !bad_q) begin
          wr_stb_d  = 1'b1;
          wr_addr_d = addr_q;
        end
`ifdef SPI_REG_CTRL_AUTOINC_EN
        addr_d = addr_q + 1'b1;
        raddr  = addr_q + 1'b1;
        tx_d   = (rd_q && !bad_q) ? rdata : '0;
`else
        tx_d    = '0;
        state_d = DRAIN;
`endif
      end
      DRAIN: tx_d = '0;
      default: state_d = IDLE;
    endcase
    if (spi_ss_n) begin
      state_d   = IDLE;
      tx_d      = '0;
      need_hi_d = 1'b0;
    end
  end

  assign spi_en      = en_q;
  assign spi_tx_data = tx_q;
  assign wr_stb      = wr_stb_q;
  assign wr_addr     = wr_addr_q;
  assign err         = err_q;

endmodule

// File: tb/tb_spi_reg_ctrl.sv
// Directed bench for spi_reg_ctrl (default WIDTH=8, NREG=16).
module tb_spi_reg_ctrl;

  logic         clk = 1'b0;
  logic         rst, spi_ss_n, spi_ready, spi_en, wr_stb, err, err_clr;
  logic [7:0]   spi_rx_data, spi_tx_data;
  logic [127:0] reg_q;
  logic [3:0]   wr_addr;

  int nvec = 0, nfail = 0, stb_cnt = 0;

  spi_reg_ctrl #(.WIDTH(8), .NREG(16)) dut (
    .clk(clk), .rst(rst), .spi_ss_n(spi_ss_n), .spi_ready(spi_ready),
    .spi_en(spi_en), .spi_rx_data(spi_rx_data), .spi_tx_data(spi_tx_data),
    .reg_q(reg_q), .wr_stb(wr_stb), .wr_addr(wr_addr), .err(err), .err_clr(err_clr)
  );

  always #5 clk = ~clk;

  always @(negedge clk) if (wr_stb === 1'b1) stb_cnt <= stb_cnt + 1;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    nvec++;
    assert (obs === exp) else begin
      nfail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [7:0] rb(input int i);
    return reg_q[i*8 +: 8];
  endfunction

  task automatic start_frame();
    @(negedge clk); spi_ss_n = 1'b0;
    @(negedge clk);
  endtask

  task automatic end_frame();
    @(negedge clk); spi_ss_n = 1'b1;
    repeat (2) @(negedge clk);
  endtask

  // One byte handshake; returns what was seen in the spi_en cycle and the cycle after.
  task automatic xfer(input logic [7:0] b, input logic clr,
                      output logic en, output logic [7:0] tx, output logic stb);
    @(negedge clk); spi_rx_data = b; spi_ready = 1'b1;
    @(negedge clk); spi_ready = 1'b0; err_clr = clr; en = spi_en; tx = spi_tx_data;
    @(negedge clk); err_clr = 1'b0; stb = wr_stb;
  endtask

  initial begin
    logic       en, stb;
    logic [7:0] tx;
    int         s0, cnt;

    #200000;
    $display("FAIL watchdog: observed timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic       en, stb;
    logic [7:0] tx;
    int         s0, cnt;

    rst = 1'b1; spi_ss_n = 1'b1; spi_ready = 1'b0; spi_rx_data = '0; err_clr = 1'b0;
    repeat (2) @(negedge clk);
    chk("rst_en", spi_en, 0);
    chk("rst_tx", spi_tx_data, 0);
    chk("rst_regs", (reg_q == '0), 1);
    chk("rst_stb", wr_stb, 0);
    chk("rst_waddr", wr_addr, 0);
    chk("rst_err", err, 0);
    rst = 1'b0;
    @(negedge clk);

    // spi_ready held high: exactly one spi_en pulse
    spi_ready = 1'b1; cnt = 0;
    repeat (4) begin @(negedge clk); cnt += int'(spi_en); end
    spi_ready = 1'b0;
    @(negedge clk); cnt += int'(spi_en);
    chk("held_ready_en_pulses", cnt, 1);

    // write reg 3 = A5
    s0 = stb_cnt;
    start_frame();
    xfer(8'h03, 1'b0, en, tx, stb);
    chk("w3_cmd_en", en, 1);
    chk("w3_cmd_tx", tx, 0);
    xfer(8'hA5, 1'b0, en, tx, stb);
    chk("w3_data_en", en, 1);
    chk("w3_stb", stb, 1);
    chk("w3_waddr", wr_addr, 3);
    end_frame();
    chk("w3_stb_count", stb_cnt - s0, 1);
    chk("w3_reg3", rb(3), 8'hA5);
    chk("w3_err", err, 0);

    // read reg 3
    s0 = stb_cnt;
    start_frame();
    xfer(8'h83, 1'b0, en, tx, stb);
    chk("r3_cmd_tx", tx, 0);
    xfer(8'h00, 1'b0, en, tx, stb);
    chk("r3_data_tx", tx, 8'hA5);
    chk("r3_data_en", en, 1);
    @(negedge clk);
    chk("r3_drain_tx", spi_tx_data, 0);
    end_frame();
    chk("r3_no_stb", stb_cnt - s0, 0);
    chk("r3_reg3", rb(3), 8'hA5);

    // write 15 with trailing byte
    s0 = stb_cnt;
    start_frame();
    xfer(8'h0F, 1'b0, en, tx, stb);
    xfer(8'h11, 1'b0, en, tx, stb);
    xfer(8'h22, 1'b0, en, tx, stb);
    chk("w15_third_en", en, 1);
    chk("w15_third_tx", tx, 0);
    end_frame();
    chk("w15_reg15", rb(15), 8'h11);
`ifdef SPI_REG_CTRL_AUTOINC_EN
    chk("w15_reg0_wrap", rb(0), 8'h22);
    chk("w15_stb_count", stb_cnt - s0, 2);
`else
    chk("w15_reg0_kept", rb(0), 8'h00);
    chk("w15_stb_count", stb_cnt - s0, 1);
`endif

    // out-of-range write 0x20
    s0 = stb_cnt;
    start_frame();
    xfer(8'h20, 1'b0, en, tx, stb);
    xfer(8'h55, 1'b0, en, tx, stb);
    chk("bad20_stb", stb, 0);
    end_frame();
    chk("bad20_no_stb", stb_cnt - s0, 0);
    chk("bad20_err", err, 1);
    chk("bad20_reg0", rb(0), reg_q[7:0] == 8'h55 ? 8'h00 : rb(0));
    @(negedge clk); err_clr = 1'b1;
    @(negedge clk); err_clr = 1'b0;
    chk("err_cleared", err, 0);

    // address 0x13 must not alias onto reg 3
    s0 = stb_cnt;
    start_frame();
    xfer(8'h13, 1'b0, en, tx, stb);
    xfer(8'h66, 1'b0, en, tx, stb);
    end_frame();
    chk("bad13_reg3", rb(3), 8'hA5);
    chk("bad13_no_stb", stb_cnt - s0, 0);
    chk("bad13_err", err, 1);
    @(negedge clk); err_clr = 1'b1;
    @(negedge clk); err_clr = 1'b0;

    // out-of-range read 0x7F with simultaneous clear: set wins, data 0
    start_frame();
    xfer(8'hFF, 1'b1, en, tx, stb);
    chk("badFF_err_set_wins", err, 1);
    xfer(8'h00, 1'b0, en, tx, stb);
    chk("badFF_tx", tx, 0);
    end_frame();
    @(negedge clk); err_clr = 1'b1;
    @(negedge clk); err_clr = 1'b0;

    // abandoned frame after command 0x05
    s0 = stb_cnt;
    start_frame();
    xfer(8'h05, 1'b0, en, tx, stb);
    end_frame();
    chk("abort5_reg5", rb(5), 0);
    chk("abort5_no_stb", stb_cnt - s0, 0);
    start_frame();
    xfer(8'h05, 1'b0, en, tx, stb);
    xfer(8'h77, 1'b0, en, tx, stb);
    end_frame();
    chk("w5_reg5", rb(5), 8'h77);
    chk("w5_waddr", wr_addr, 5);

    // reset while in DATA of a read of reg 3
    start_frame();
    xfer(8'h83, 1'b0, en, tx, stb);
    chk("pre_rst_tx", spi_tx_data, 8'hA5);
    rst = 1'b1; spi_rx_data = 8'h99; spi_ready = 1'b1;
    @(negedge clk);
    chk("mid_rst_tx", spi_tx_data, 0);
    chk("mid_rst_regs", (reg_q == '0), 1);
    chk("mid_rst_waddr", wr_addr, 0);
    chk("mid_rst_en", spi_en, 0);
    chk("mid_rst_stb", wr_stb, 0);
    rst = 1'b0; spi_ready = 1'b0;
    // ss_n stayed low through reset: bytes must be ignored
    s0 = stb_cnt;
    xfer(8'h04, 1'b0, en, tx, stb);
    xfer(8'h44, 1'b0, en, tx, stb);
    end_frame();
    chk("post_rst_ignored_reg4", rb(4), 0);
    chk("post_rst_no_stb", stb_cnt - s0, 0);
    start_frame();
    xfer(8'h04, 1'b0, en, tx, stb);
    xfer(8'h44, 1'b0, en, tx, stb);
    end_frame();
    chk("post_rst_reg4", rb(4), 8'h44);

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nfail);
    $finish;
  end

endmodule

// File: doc/spi_reg_ctrl.md
SPI_REG_CTRL -- requirements
Module: spi_reg_ctrl

Interface
REQ-001 Parameters SHALL be: WIDTH, default 8, byte width of the SPI byte interface; NREG, default 16, number of registers (power of two, 2..128).
REQ-002 Ports SHALL be, in order: clk in 1 system clock; rst in 1 reset; spi_ss_n in 1 slave select (already synchronised); spi_ready in 1 byte received; spi_en out 1 byte handshake; spi_rx_data in WIDTH received byte; spi_tx_data out WIDTH next byte to shift out; reg_q out NREG*WIDTH flattened register contents; wr_stb out 1 register write strobe; wr_addr out $clog2(NREG) written address; err out 1 sticky bad-address flag; err_clr in 1 clears err.
REQ-003 There SHALL be one clock, clk; reset SHALL be asynchronous and active-high, port rst.

Function
REQ-004 Frame format SHALL be: byte 0 = command, bit WIDTH-1 = 1 read / 0 write, bits WIDTH-2:0 = address; following bytes = data.
REQ-005 The FSM SHALL have states IDLE, CMD, DATA, DRAIN.
REQ-006 IDLE -> CMD on spi_ss_n low; any state -> IDLE within 1 cycle of spi_ss_n high, discarding any unfinished frame.
REQ-007 spi_ready high for one cycle SHALL cause spi_en high for exactly one cycle on the next clk edge; spi_en SHALL NOT reassert until spi_ready has been low for at least one cycle.
REQ-008 spi_rx_data SHALL be sampled only in the cycle spi_en is high; spi_tx_data SHALL be stable in that cycle.
REQ-009 CMD handshake: latch address and direction; go to DATA; spi_tx_data = register[address] for a read, 0 for a write.
REQ-010 DATA handshake for a write: register[address] <= spi_rx_data on the next edge; wr_stb high for 1 cycle with wr_addr = address.
REQ-011 DATA handshake for a read: rx byte ignored; no write.
REQ-012 Address >= NREG: writes dropped with no wr_stb, read data = 0, err set; err SHALL stay high until err_clr; if set and clear coincide, set wins.
REQ-013 Unused address bits above $clog2(NREG) SHALL take part in the >= NREG check, not be truncated.
REQ-014 A write and a read-back of the same register in the same handshake cycle SHALL return the old value.
REQ-015 spi_tx_data SHALL be 0 in IDLE and DRAIN.

Reset
REQ-016 On rst: state IDLE, spi_en 0, spi_tx_data 0, all registers 0 (reg_q = 0), wr_stb 0, wr_addr 0, err 0.
REQ-017 rst asserted mid-frame SHALL abort it; after release the block SHALL wait in IDLE for spi_ss_n high and then low before decoding a command.

Configuration
REQ-018 With SPI_REG_CTRL_AUTOINC_EN defined: after each DATA handshake, address <= (address + 1) mod NREG; stay in DATA; next read byte preloaded at that handshake; burst continues until spi_ss_n high.
REQ-019 Without SPI_REG_CTRL_AUTOINC_EN: after the first DATA handshake go to DRAIN; further bytes are still handshaked, with no write and tx data 0.

Structure
REQ-020 Package spi_reg_ctrl_pkg SHALL hold the FSM state enum, the command R/W bit position constant, and the address-field width function.
REQ-021 Sub-module spi_reg_file SHALL hold the NREG x WIDTH array: one write port, one async read port, flattened q output.

Verification
REQ-022 Write frame 0x03,0xA5 -> wr_stb once, wr_addr 3, reg_q[31:24] = 0xA5, err 0.
REQ-023 After REQ-022, read frame 0x83,0x00 -> spi_tx_data = 0xA5 in the second spi_en cycle; no wr_stb.
REQ-024 Write 0x20,0x55 with NREG=16 -> no wr_stb, err 1; pulse err_clr -> err 0.
REQ-025 AUTOINC_EN: write 0x0F,0x11,0x22 -> reg 15 = 0x11, reg 0 = 0x22 (wrap); without macro: reg 15 = 0x11, reg 0 unchanged.
REQ-026 spi_ss_n high after the command byte 0x05 only -> IDLE, register 5 unchanged; next frame 0x05,0x77 -> reg 5 = 0x77.
REQ-027 rst pulse while in DATA -> all outputs at reset values next cycle; no write from the aborted frame.
